// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational 16-bit ALU among NUM_REQ requesters.
// Optional macro ALU_ARB_DIVZERO_EN: divide/modulo by zero returns 16'hFFFF and raises err.

module alu_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [3*NUM_REQ-1:0]  op,
  input  logic [16*NUM_REQ-1:0] in1,
  input  logic [16*NUM_REQ-1:0] in2,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [15:0]           result,
  output logic                  err,
  output logic                  busy,
  output logic [2:0]            alu_op,
  output logic [15:0]           alu_in1,
  output logic [15:0]           alu_in2,
  input  logic [15:0]           alu_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [2:0]          op_q, op_d;
  logic [15:0]         in1_q, in1_d;
  logic [15:0]         in2_q, in2_d;
  logic [15:0]         result_q, result_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic [2:0]          op_a  [NUM_REQ];
  logic [15:0]         in1_a [NUM_REQ];
  logic [15:0]         in2_a [NUM_REQ];
  logic                win_found;
  logic [IW-1:0]       win_idx;

  always_comb begin : unpack
    for (int k = 0; k < NUM_REQ; k++) begin
      op_a[k]  = op[k*3 +: 3];
      in1_a[k] = in1[k*16 +: 16];
      in2_a[k] = in2[k*16 +: 16];
    end
  end

  // Scan starts at ptr_q and wraps; the first asserted request wins.
  always_comb begin : pick
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin : next_state
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    op_d     = op_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    result_d = result_q;
    grant_d  = '0;
    done_d   = '0;
    err_d    = 1'b0;
    busy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = EXEC;
          idx_d   = win_idx;
          op_d    = op_a[win_idx];
          in1_d   = in1_a[win_idx];
          in2_d   = in2_a[win_idx];
          grant_d = NUM_REQ'(1) << win_idx;
          busy_d  = 1'b1;
          ptr_d   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      EXEC: begin
        state_d  = DONE;
        done_d   = NUM_REQ'(1) << idx_q;
        result_d = alu_out;
        busy_d   = 1'b1;
`ifdef ALU_ARB_DIVZERO_EN
        if ((op_q == 3'd3 || op_q == 3'd5) && in1_q == 16'd0) begin
          result_d = 16'hFFFF;
          err_d    = 1'b1;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; every register, including the operand latches, resets to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      op_q     <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      result_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      result_q <= result_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign result  = result_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign alu_op  = op_q;
  assign alu_in1 = in1_q;
  assign alu_in2 = in2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model; the bench also plays the ALU.

module tb_alu_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [3*N-1:0]  op;
  logic [16*N-1:0] in1;
  logic [16*N-1:0] in2;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic [15:0]     result;
  logic            err;
  logic            busy;
  logic [2:0]      alu_op;
  logic [15:0]     alu_in1;
  logic [15:0]     alu_in2;
  logic [15:0]     alu_out;

  int vectors     = 0;
  int miscompares = 0;

  alu_arbiter #(.NUM_REQ(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .in1     (in1),
    .in2     (in2),
    .grant   (grant),
    .done    (done),
    .result  (result),
    .err     (err),
    .busy    (busy),
    .alu_op  (alu_op),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_out (alu_out)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; a zero divisor yields 0 so the raw path stays defined.
  function automatic logic [15:0] alu_fn(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return (a == 16'd0) ? 16'd0 : b / a;
      3'd4:    return b;
      3'd5:    return (a == 16'd0) ? 16'd0 : b % a;
      default: return a + b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_in1, alu_in2);

  function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
`ifdef ALU_ARB_DIVZERO_EN
    if ((o == 3'd3 || o == 3'd5) && a == 16'd0) return 16'hFFFF;
`endif
    return alu_fn(o, a, b);
  endfunction

  function automatic logic ref_err(input logic [2:0] o, input logic [15:0] a);
`ifdef ALU_ARB_DIVZERO_EN
    return (o == 3'd3 || o == 3'd5) && a == 16'd0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    op[i*3 +: 3]   = o;
    in1[i*16 +: 16] = a;
    in2[i*16 +: 16] = b;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    op    = '0;
    in1   = '0;
    in2   = '0;
    #2;
    vectors++; if ({grant, done, result, err, busy, alu_op, alu_in1, alu_in2} !== '0) begin miscompares++; $display("FAIL reset_outputs: got grant=%b done=%b result=%h err=%b busy=%b alu=%h/%h/%h want all zero", grant, done, result, err, busy, alu_op, alu_in1, alu_in2); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    set_slot(0, 3'd0, 16'd3, 16'd4);
    req = 4'b0001;
    tick();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL add_grant: got %b want 0001", grant); end
    vectors++; if (busy !== 1'b1 || done !== 4'b0000) begin miscompares++; $display("FAIL add_grant_cycle: got busy=%b done=%b want busy=1 done=0000", busy, done); end
    req = '0;
    tick();
    vectors++; if (done !== 4'b0001 || result !== 16'd7) begin miscompares++; $display("FAIL add_done: got done=%b result=%0d want done=0001 result=7", done, result); end
    vectors++; if (grant !== 4'b0000 || busy !== 1'b1) begin miscompares++; $display("FAIL add_done_cycle: got grant=%b busy=%b want grant=0000 busy=1", grant, busy); end
    tick();
    vectors++; if (done !== 4'b0000 || busy !== 1'b0 || result !== 16'd7) begin miscompares++; $display("FAIL add_after: got done=%b busy=%b result=%0d want done=0000 busy=0 result=7", done, busy, result); end
  endtask

  task automatic test_all_mul();
    logic [N-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < N; i++) set_slot(i, 3'd2, 16'd300, 16'd300);
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      exp_g    = '0;
      exp_g[i] = 1'b1;
      tick();
      vectors++; if (grant !== exp_g) begin miscompares++; $display("FAIL mul_grant%0d: got %b want %b", i, grant, exp_g); end
      req[i] = 1'b0;
      tick();
      vectors++; if (done !== exp_g || result !== 16'h5F90) begin miscompares++; $display("FAIL mul_done%0d: got done=%b result=%h want done=%b result=5f90", i, done, result, exp_g); end
      tick();
    end
  endtask

  task automatic test_fairness();
    int exp_seq [4] = '{1, 2, 1, 2};
    logic [N-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < N; i++) set_slot(i, 3'd4, 16'd0, 16'(i + 1));
    req = 4'b0010;
    for (int n = 0; n < 4; n++) begin
      exp_g = '0;
      exp_g[exp_seq[n]] = 1'b1;
      tick();
      vectors++; if (grant !== exp_g) begin miscompares++; $display("FAIL fair_grant%0d: got %b want %b", n, grant, exp_g); end
      req[2] = 1'b1;
      tick();
      tick();
    end
    req = 4'b1000;
    tick();
    vectors++; if (grant !== 4'b1000) begin miscompares++; $display("FAIL fair_grant3: got %b want 1000", grant); end
    req = 4'b1011;
    tick();
    tick();
    tick();
    vectors++; if (grant !== 4'b0001) begin miscompares++; $display("FAIL fair_wrap: got %b want 0001", grant); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_divzero();
    apply_reset();
    set_slot(0, 3'd3, 16'd0, 16'd50);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
`ifdef ALU_ARB_DIVZERO_EN
    vectors++; if (result !== 16'hFFFF || err !== 1'b1) begin miscompares++; $display("FAIL divzero: got result=%h err=%b want result=ffff err=1", result, err); end
`else
    vectors++; if (result !== 16'h0000 || err !== 1'b0) begin miscompares++; $display("FAIL divzero_raw: got result=%h err=%b want result=0000 err=0", result, err); end
`endif
    tick();
    vectors++; if (err !== 1'b0 || done !== 4'b0000) begin miscompares++; $display("FAIL divzero_clear: got err=%b done=%b want err=0 done=0000", err, done); end
    set_slot(0, 3'd5, 16'd7, 16'd50);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    vectors++; if (result !== 16'd1 || err !== 1'b0 || done !== 4'b0001) begin miscompares++; $display("FAIL mod7: got result=%0d err=%b done=%b want result=1 err=0 done=0001", result, err, done); end
    tick();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    set_slot(1, 3'd1, 16'd5, 16'd2);
    req = 4'b0010;
    tick();
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL midrst_grant: got %b want 0010", grant); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({grant, done, result, err, busy, alu_op, alu_in1, alu_in2} !== '0) begin miscompares++; $display("FAIL midrst_outputs: got grant=%b done=%b result=%h busy=%b alu=%h/%h/%h want all zero", grant, done, result, busy, alu_op, alu_in1, alu_in2); end
    tick();
    vectors++; if (done !== 4'b0000) begin miscompares++; $display("FAIL midrst_nodone: got %b want 0000", done); end
    set_slot(2, 3'd0, 16'd40, 16'd2);
    req   = 4'b0110;
    rst_n = 1'b1;
    tick();
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL midrst_ptr: got %b want 0010", grant); end
    req = '0;
    tick();
    vectors++; if (done !== 4'b0010 || result !== 16'd3) begin miscompares++; $display("FAIL midrst_done: got done=%b result=%0d want done=0010 result=3", done, result); end
    tick();
  endtask

  task automatic test_operand_change();
    set_slot(1, 3'd1, 16'd10, 16'd3);
    req = 4'b0010;
    tick();
    vectors++; if (grant !== 4'b0010) begin miscompares++; $display("FAIL opchg_grant: got %b want 0010", grant); end
    set_slot(1, 3'd1, 16'd99, 16'd1);
    req = '0;
    vectors++; if (alu_op !== 3'd1 || alu_in1 !== 16'd10 || alu_in2 !== 16'd3) begin miscompares++; $display("FAIL opchg_alu: got %0d/%0d/%0d want 1/10/3", alu_op, alu_in1, alu_in2); end
    tick();
    vectors++; if (result !== 16'd7 || done !== 4'b0010) begin miscompares++; $display("FAIL opchg_result: got result=%0d done=%b want result=7 done=0010", result, done); end
    tick();
  endtask

  task automatic test_random(input int cycles);
    int          cyc, next_sample, ptr_m, g_cyc, g_w, w;
    bit          act, g_err, e_err;
    logic [15:0] g_res, last_res, l_in1, l_in2;
    logic [2:0]  l_op;
    logic [N-1:0] e_grant, e_done;
    logic        e_busy;
    apply_reset();
    cyc = 0; next_sample = 0; ptr_m = 0; act = 1'b0; g_cyc = 0; g_w = 0;
    g_res = '0; g_err = 1'b0; last_res = '0; l_op = '0; l_in1 = '0; l_in2 = '0;
    for (int n = 0; n < cycles; n++) begin
      req = N'($urandom) & N'($urandom);
      for (int i = 0; i < N; i++)
        set_slot(i, 3'($urandom), ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom), 16'($urandom));
      if (cyc >= next_sample && req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(ptr_m + k) % N]) w = (ptr_m + k) % N;
        l_op        = op[w*3 +: 3];
        l_in1       = in1[w*16 +: 16];
        l_in2       = in2[w*16 +: 16];
        g_res       = ref_result(l_op, l_in1, l_in2);
        g_err       = ref_err(l_op, l_in1);
        act         = 1'b1;
        g_cyc       = cyc;
        g_w         = w;
        next_sample = cyc + 3;
        ptr_m       = (w + 1) % N;
      end
      tick();
      e_grant = '0;
      e_done  = '0;
      e_err   = 1'b0;
      if (act && cyc == g_cyc) e_grant[g_w] = 1'b1;
      if (act && cyc == g_cyc + 1) begin
        e_done[g_w] = 1'b1;
        last_res    = g_res;
        e_err       = g_err;
      end
      e_busy = act && (cyc == g_cyc || cyc == g_cyc + 1);
      vectors++; if (grant !== e_grant) begin miscompares++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant, e_grant); end
      vectors++; if (done !== e_done) begin miscompares++; $display("FAIL rnd_done@%0d: got %b want %b", cyc, done, e_done); end
      vectors++; if (busy !== e_busy) begin miscompares++; $display("FAIL rnd_busy@%0d: got %b want %b", cyc, busy, e_busy); end
      vectors++; if (result !== last_res) begin miscompares++; $display("FAIL rnd_result@%0d: got %h want %h", cyc, result, last_res); end
      vectors++; if (err !== e_err) begin miscompares++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, err, e_err); end
      vectors++; if (alu_op !== l_op || alu_in1 !== l_in1 || alu_in2 !== l_in2) begin miscompares++; $display("FAIL rnd_alu@%0d: got %h/%h/%h want %h/%h/%h", cyc, alu_op, alu_in1, alu_in2, l_op, l_in1, l_in2); end
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_add();
    test_all_mul();
    test_fairness();
    test_divzero();
    test_reset_midop();
    test_operand_change();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
